// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types for the I2S receiver (state encoding, stereo-pair layout).
package i2s_pkg;
  localparam int SAMPLE_WIDTH_DEF = 16;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH_DEF-1:0] left;
    logic [SAMPLE_WIDTH_DEF-1:0] right;
  } stereo_pair_t;
endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: show-ahead FIFO; extra pointer bit separates full from empty.
module i2s_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, do_push, do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S serial-to-parallel receiver feeding a show-ahead stereo-pair FIFO.
// Define I2S_RX_FRAME_ERR_EN to flag and drop pairs containing a word of the wrong length.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    serial_clk,
  input  logic                    reset,
  input  logic                    i2s_ws,
  input  logic                    i2s_sound_bit_in,
  input  logic                    sample_ready,
  output logic                    sample_valid,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    overflow,
  output logic                    frame_err
);
  localparam logic [SAMPLE_WIDTH-1:0] MASK_INIT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  state_t                    state;
  logic                      ws_q, left_ok;
  logic [SAMPLE_WIDTH-1:0]   shreg, bit_mask, left_hold, word;
  logic                      ws_edge, word_ok, push, pop, full, valid;
  logic [2*SAMPLE_WIDTH-1:0] head;

  // bit_mask is a one-hot bit position walking MSB->LSB; once it falls off the
  // end, excess bits are dropped and short words stay zero-padded
  assign ws_edge = i2s_ws != ws_q;
  assign word    = shreg | (i2s_sound_bit_in ? bit_mask : '0);

`ifdef I2S_RX_FRAME_ERR_EN
  // exactly SAMPLE_WIDTH-1 bits shifted before the final bit leaves the mask at bit 0
  assign word_ok = bit_mask[0];
`else
  assign word_ok = 1'b1;
`endif

  assign push = ws_edge && ws_q && (state == RIGHT) && left_ok && word_ok;
  assign pop  = valid && sample_ready;

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      ws_q      <= 1'b0;
      state     <= SYNC;
      shreg     <= '0;
      bit_mask  <= MASK_INIT;
      left_hold <= '0;
      left_ok   <= 1'b0;
    end else begin
      ws_q <= i2s_ws;
      if (ws_edge) begin
        shreg    <= '0;
        bit_mask <= MASK_INIT;
        case (state)
          SYNC:    if (ws_q) state <= LEFT;
          LEFT: begin
            left_hold <= word;
            left_ok   <= word_ok;
            state     <= RIGHT;
          end
          RIGHT:   state <= LEFT;
          default: state <= SYNC;
        endcase
      end else begin
        shreg    <= word;
        bit_mask <= bit_mask >> 1;
      end
    end
  end

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset)                    overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

`ifdef I2S_RX_FRAME_ERR_EN
  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= ws_edge && (state != SYNC) && !word_ok;
  end
`else
  assign frame_err = 1'b0;
`endif

  i2s_sample_fifo #(
    .WIDTH (2*SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (serial_clk),
    .rst   (reset),
    .push  (push),
    .wdata ({left_hold, word}),
    .pop   (pop),
    .valid (valid),
    .full  (full),
    .rdata (head)
  );

  assign sample_valid = valid;
  assign left_sample  = valid ? head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH] : '0;
  assign right_sample = valid ? head[SAMPLE_WIDTH-1:0] : '0;
endmodule
